// File: rtl/mac_share_pkg.sv
// Shared types and default sizes for the MAC sharing arbiter.
package mac_share_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REQ    = 4;

    // Sequencing of one shared MAC operation
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        RESP
    } state_t;

endpackage

// File: rtl/mac_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_next,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from ptr upwards; the first hit wins and later hits are masked by valid
    always_comb begin
        int               j;
        logic [IDX_W-1:0] jj;
        gnt_next = '0;
        idx      = '0;
        valid    = 1'b0;
        j        = 0;
        jj       = '0;
        for (int off = 0; off < N; off++) begin
            j = int'(ptr) + off;
            if (j >= N) j = j - N;
            jj = IDX_W'(j);
            if (!valid && req[jj]) begin
                valid        = 1'b1;
                gnt_next[jj] = 1'b1;
                idx          = jj;
            end
        end
    end

endmodule

// File: rtl/mac_share_arbiter.sv
// Round-robin sharing of one multi-cycle MAC. The accumulator is never cleared,
// so each op's a*b is recovered as (accumulator after) - (accumulator before).
module mac_share_arbiter
    import mac_share_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int IDX_W        = $clog2(NUM_REQ),
    parameter int BUSY_TIMEOUT = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         result,
    output logic [IDX_W-1:0]              owner,
    output logic                          mac_start,
    output logic [DATA_WIDTH-1:0]         mac_a,
    output logic [DATA_WIDTH-1:0]         mac_b,
    input  logic                          mac_busy,
    input  logic [DATA_WIDTH-1:0]         mac_dout
);

    // Counter only needs to reach BUSY_TIMEOUT-1
    localparam int              TMO_W    = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    state_t                                state, state_nxt;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    op_a, op_b;
    logic [NUM_REQ-1:0]                    pick_oh;
    logic [IDX_W-1:0]                      pick_idx;
    logic                                  pick_vld;
    logic [IDX_W-1:0]                      rr_ptr;
    logic [DATA_WIDTH-1:0]                 base;
    logic [TMO_W-1:0]                      tmo_cnt;
    logic                                  grant_go;
    logic                                  enter_resp;

    // Packed view of the flat operand buses, requester i at slice i
    assign op_a = req_a;
    assign op_b = req_b;

    rr_priority_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (req),
        .ptr      (rr_ptr),
        .gnt_next (pick_oh),
        .idx      (pick_idx),
        .valid    (pick_vld)
    );

    // A busy MAC while idle is a stale op; hold off new grants until it settles
    assign grant_go   = (state == IDLE) && pick_vld && !mac_busy;
    assign enter_resp = (state_nxt == RESP) && (state != RESP);
    assign mac_start  = (state == ISSUE);
    assign done       = (state == RESP) ? gnt : '0;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: issue, wait for busy to rise (or time out), wait for it to fall, respond
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_go) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (mac_busy)                  state_nxt = WAIT_LO;
                else if (tmo_cnt == TMO_LAST)  state_nxt = RESP;
            end
            WAIT_LO: if (!mac_busy) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant capture, accumulator snapshot, timeout count, result and pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt     <= '0;
            owner   <= '0;
            mac_a   <= '0;
            mac_b   <= '0;
            base    <= '0;
            result  <= '0;
            rr_ptr  <= '0;
            tmo_cnt <= '0;
        end else begin
            if (grant_go) begin
                gnt   <= pick_oh;
                owner <= pick_idx;
                mac_a <= op_a[pick_idx];
                mac_b <= op_b[pick_idx];
                base  <= mac_dout;
            end
            if (state == ISSUE)
                tmo_cnt <= '0;
            else if (state == WAIT_HI && !mac_busy)
                tmo_cnt <= tmo_cnt + 1'b1;
            // Modular difference makes accumulator wrap harmless
            if (enter_resp)
                result <= mac_dout - base;
            if (state == RESP) begin
                gnt    <= '0;
                rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Randomized scoreboard bench for mac_share_arbiter with a behavioural MAC.
module tb_mac_share_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int BT = 2;
    localparam int MAXOPS = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req = '0;
    logic [NR*DW-1:0] req_a = '0;
    logic [NR*DW-1:0] req_b = '0;
    logic [NR-1:0]    gnt, done;
    logic [DW-1:0]    result;
    logic [IW-1:0]    owner;
    logic             mac_start;
    logic [DW-1:0]    mac_a, mac_b;
    logic             mac_busy;
    logic [DW-1:0]    mac_dout;

    always #5 clk = ~clk;

    mac_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .IDX_W(IW), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .done(done), .result(result), .owner(owner),
        .mac_start(mac_start), .mac_a(mac_a), .mac_b(mac_b),
        .mac_busy(mac_busy), .mac_dout(mac_dout)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Behavioural MAC: latches operands on start, busy for a few cycles unless b=0,
    // adds a*b into a never-cleared accumulator as busy falls.
    logic          busy_m;
    logic          stale = 1'b0;
    logic [DW-1:0] acc, la, lb;
    int            bcnt;
    int            force_dur = 0;
    assign mac_busy = busy_m | stale;
    assign mac_dout = acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_m <= 1'b0; acc <= '0; bcnt <= 0; la <= '0; lb <= '0;
        end else if (mac_start) begin
            la <= mac_a; lb <= mac_b;
            if (mac_b != '0) begin
                busy_m <= 1'b1;
                bcnt   <= (force_dur > 0) ? force_dur : int'($urandom_range(1, 5));
            end
        end else if (busy_m) begin
            if (bcnt <= 1) begin busy_m <= 1'b0; acc <= acc + la * lb; end
            else bcnt <= bcnt - 1;
        end
    end

    // Scoreboard
    typedef struct {
        int            idx;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] res;
    } exp_t;
    exp_t exp_q[$];
    exp_t op_q[$];

    // Monitor: compares whatever the DUT presents against the queued expectations
    logic [NR-1:0] prev_done = '0;
    logic          prev_start = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_done  <= '0;
            prev_start <= 1'b0;
        end else begin
            if (mac_start) begin
                chk("start_single_pulse", {63'd0, prev_start}, 64'd0);
                if (op_q.size() == 0) chk("unexpected_start", 64'd1, 64'd0);
                else begin
                    exp_t o;
                    o = op_q.pop_front();
                    chk("mac_a", mac_a, o.a);
                    chk("mac_b", mac_b, o.b);
                end
            end
            if (prev_done != '0) chk("gnt_clear_after_done", gnt, 64'd0);
            if (done != '0) begin
                if (exp_q.size() == 0) chk("unexpected_done", done, 64'd0);
                else begin
                    exp_t e;
                    logic [NR-1:0] oh;
                    e = exp_q.pop_front();
                    oh = '0;
                    oh[e.idx] = 1'b1;
                    chk("done_onehot", done, oh);
                    chk("gnt_at_done", gnt, oh);
                    chk("owner", owner, e.idx);
                    chk("result", result, e.res);
                end
            end
            prev_done  <= done;
            prev_start <= mac_start;
        end
    end

    // Stimulus state and reference arbitration model
    logic [DW-1:0] opa[NR][MAXOPS];
    logic [DW-1:0] opb[NR][MAXOPS];
    int            nops[NR];
    int            m_ptr = 0;

    task automatic clr();
        for (int i = 0; i < NR; i++) nops[i] = 0;
    endtask

    // Every pending requester stays high until its last done, so each grant decision
    // sees the same pending set: the first requester with work left at/after m_ptr.
    task automatic predict();
        int rem[NR];
        int k[NR];
        int left;
        left = 0;
        for (int i = 0; i < NR; i++) begin rem[i] = nops[i]; k[i] = 0; left += nops[i]; end
        while (left > 0) begin
            int j;
            exp_t e;
            j = 0;
            for (int off = 0; off < NR; off++) begin
                j = (m_ptr + off) % NR;
                if (rem[j] > 0) break;
            end
            e.idx = j; e.a = opa[j][k[j]]; e.b = opb[j][k[j]];
            e.res = e.a * e.b;
            exp_q.push_back(e);
            op_q.push_back(e);
            k[j]++; rem[j]--; left--;
            m_ptr = (j + 1) % NR;
        end
    endtask

    task automatic run_batch();
        int k[NR];
        int total, cyc, budget;
        predict();
        total = 0;
        for (int i = 0; i < NR; i++) begin
            k[i] = 0;
            total += nops[i];
            if (nops[i] > 0) begin
                req[i] = 1'b1;
                req_a[i*DW +: DW] = opa[i][0];
                req_b[i*DW +: DW] = opb[i][0];
            end
        end
        budget = total * 16 + 40;
        cyc = 0;
        while (req != '0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NR; i++) begin
                if (req[i] && done[i]) begin
                    k[i]++;
                    if (k[i] >= nops[i]) req[i] = 1'b0;
                    else begin
                        req_a[i*DW +: DW] = opa[i][k[i]];
                        req_b[i*DW +: DW] = opb[i][k[i]];
                    end
                end else if (req[i] && gnt[i] && $urandom_range(0, 1) == 1) begin
                    // operands must already be latched; scribble over them
                    req_a[i*DW +: DW] = $urandom;
                    req_b[i*DW +: DW] = $urandom;
                end
            end
        end
        if (req != '0) begin
            chk("batch_timeout", {60'd0, req}, 64'd0);
            req = '0;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset values
        #3;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_owner", owner, 0);
        chk("rst_mac_start", {63'd0, mac_start}, 0);
        chk("rst_mac_a", mac_a, 0);
        chk("rst_mac_b", mac_b, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single request, 4-cycle MAC
        clr(); force_dur = 4;
        nops[0] = 1; opa[0][0] = 5; opb[0][0] = 3;
        run_batch();

        // Full contention, a=i+1, b=2
        clr();
        for (int i = 0; i < NR; i++) begin nops[i] = 1; opa[i][0] = DW'(i + 1); opb[i][0] = 2; end
        run_batch();
        force_dur = 0;

        // Two requesters held for 6 ops total: must alternate
        clr();
        nops[1] = 3; nops[2] = 3;
        for (int k = 0; k < 3; k++) begin
            opa[1][k] = $urandom; opb[1][k] = $urandom;
            opa[2][k] = $urandom; opb[2][k] = $urandom;
        end
        run_batch();

        // Zero-length op followed by a normal op
        clr();
        nops[0] = 2; opa[0][0] = 7; opb[0][0] = 0; opa[0][1] = 2; opb[0][1] = 2;
        run_batch();

        // Accumulator wrap
        clr();
        nops[1] = 2;
        opa[1][0] = 32'hFFFF_FFF0 - acc; opb[1][0] = 1;
        opa[1][1] = 32'h20;              opb[1][1] = 1;
        run_batch();

        // Stale busy while idle blocks the grant
        clr();
        nops[0] = 1; opa[0][0] = 6; opb[0][0] = 6;
        stale = 1'b1;
        req[0] = 1'b1; req_a[DW-1:0] = 6; req_b[DW-1:0] = 6;
        repeat (4) begin
            @(negedge clk);
            chk("stale_busy_blocks", gnt, 0);
        end
        stale = 1'b0;
        run_batch();

        // Leave the pointer at 3, then reset in the middle of requester 3's op
        clr();
        nops[2] = 1; opa[2][0] = 9; opb[2][0] = 4;
        run_batch();
        begin
            exp_t o;
            int w;
            force_dur = 30;
            o.idx = 3; o.a = 11; o.b = 3; o.res = 33;
            op_q.push_back(o);
            req[3] = 1'b1; req_a[3*DW +: DW] = 11; req_b[3*DW +: DW] = 3;
            w = 0;
            while (!mac_busy && w < 20) begin @(negedge clk); w++; end
            chk("busy_rose_before_reset", {63'd0, mac_busy}, 1);
            @(negedge clk);
            @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk("midrst_gnt", gnt, 0);
            chk("midrst_done", done, 0);
            chk("midrst_mac_start", {63'd0, mac_start}, 0);
            chk("midrst_result", result, 0);
            req = '0;
            op_q.delete();
            exp_q.delete();
            force_dur = 0;
            @(negedge clk);
            rst = 1'b0;
            m_ptr = 0;
        end
        clr();
        nops[2] = 1; opa[2][0] = 3; opb[2][0] = 5;
        nops[3] = 1; opa[3][0] = 4; opb[3][0] = 5;
        run_batch();

        // Random batches
        for (int n = 0; n < 20; n++) begin
            clr();
            for (int i = 0; i < NR; i++) begin
                nops[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 3));
                for (int k = 0; k < MAXOPS; k++) begin
                    opa[i][k] = $urandom;
                    opb[i][k] = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
                end
            end
            run_batch();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        chk("exp_q_drained", exp_q.size(), 0);
        chk("op_q_drained", op_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
